evm_result_reader: RTL and testbench
====================================

Name: evm_result_reader

Overview:
- Read-out end of the EVM tally path. Holds one saturating vote counter per candidate and accepts single-cycle vote strobes.
- When results are requested, it closes the poll and streams every candidate's count over a valid/ready handshake.
- It tracks the winner and detects ties during the stream, then presents the final result.
- Sits between the ballot-unit button logic (upstream) and the display/result serializer (downstream).

Parameters:
- NUM_CAND, 4: number of candidates (2..8).
- CW, 10: counter width in bits; counts saturate at 2^CW-1.
- SW, 3: width of the candidate index; must satisfy 2^SW >= NUM_CAND.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- vote_en  in  1  one-cycle vote strobe.
- vote_sel  in  SW  candidate index for vote_en.
- clear  in  1  zero all counters and reopen the poll.
- result_req  in  1  start (or restart) the result scan.
- out_valid  out  1  out_cand/out_count hold a valid beat.
- out_ready  in  1  downstream accepts the beat.
- out_cand  out  SW  candidate index of the current beat.
- out_count  out  CW  vote count of the current beat.
- busy  out  1  high while in READ.
- done  out  1  high while in DONE; winner outputs are valid.
- winner  out  SW  index of the highest count.
- winner_count  out  CW  highest count.
- tie  out  1  two or more candidates share the highest count.

Behaviour:
- Reset (asynchronous, any state):
  - All counters cleared to 0; state returns to IDLE.
  - out_valid, busy, done, tie are 0; out_cand, out_count, winner, winner_count are 0.
  - A reset asserted mid-scan aborts the stream immediately, with no further beats.
- FSM states: IDLE (poll open), READ (streaming), DONE (result held).
- IDLE:
  - vote_en=1 with vote_sel<NUM_CAND increments that counter at the next edge.
  - vote_sel>=NUM_CAND is ignored. A counter at 2^CW-1 stays there (saturates, no wrap).
  - result_req=1: transition to READ next edge. A vote strobed in that same cycle is still counted, and the scan sees it.
  - clear=1: all counters go to 0. clear takes priority over vote_en and over result_req in the same cycle.
- READ:
  - First beat appears 1 cycle after result_req: out_valid=1, out_cand=0, out_count=count[0].
  - A beat is transferred on a cycle where out_valid & out_ready. out_cand/out_count are held stable until the transfer.
  - After each transfer out_cand increments; out_valid stays high, with no bubbles between beats.
  - vote_en, clear, and result_req are ignored while in READ.
  - Winner tracking, updated on each transfer:
    - First beat loads winner=0, winner_count=count[0], tie=0.
    - A later count > winner_count updates winner and winner_count and clears tie.
    - A later count == winner_count sets tie=1 and keeps the lower index.
    - A count < winner_count changes nothing.
  - The transfer of beat NUM_CAND-1 moves the FSM to DONE next edge; out_valid drops to 0.
- DONE:
  - done=1; winner, winner_count, tie held.
  - result_req: rescan. done=0, go to READ, and the first beat appears next cycle.
  - clear: counters go to 0, state goes to IDLE, done=0, and winner outputs go to 0.
  - vote_en is ignored (poll closed).
- All-zero poll: winner=0, winner_count=0, tie=1.
- busy=1 exactly while in READ.
- Counters are never modified by reading.

Test Plan:
- Reset then 3 votes cand1, 1 vote cand2, result_req, out_ready=1 -> beats (0,0),(1,3),(2,1),(3,0) on 4 consecutive cycles; then done=1, winner=1, winner_count=3, tie=0.
- Drive 1023 votes on cand0 and then 5 more -> count[0] reads 1023 (saturated); vote_sel=5 strobes leave all counts unchanged.
- cand1=2, cand3=2, others 0 -> winner=1, winner_count=2, tie=1. Also no votes at all -> winner=0, winner_count=0, tie=1.
- out_ready held low for 3 cycles on beat 1 -> out_cand=1 with its count held stable, no beat skipped; vote_en during READ is ignored, verified by a rescan showing identical counts.
- Assert rst asynchronously mid-READ -> out_valid, busy, done go 0 immediately; a subsequent result_req streams all-zero counts.
- In DONE, pulse result_req -> identical stream replays. Then pulse clear -> state IDLE with counters 0. vote_en and clear asserted in the same cycle -> counter stays 0.

Source files
------------

// File: rtl/evm_result_reader_if.sv
// Handshake/bus bundle for the EVM result reader: vote strobes and control
// from the ballot unit, streamed count beats and final result to the display.
interface evm_result_reader_if #(
  parameter int SW = 3,
  parameter int CW = 10
);
  logic          vote_en;
  logic [SW-1:0] vote_sel;
  logic          clear;
  logic          result_req;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_cand;
  logic [CW-1:0] out_count;
  logic          busy;
  logic          done;
  logic [SW-1:0] winner;
  logic [CW-1:0] winner_count;
  logic          tie;

  // Side that issues votes/commands and consumes the beat stream.
  modport master (
    output vote_en, vote_sel, clear, result_req, out_ready,
    input  out_valid, out_cand, out_count, busy, done, winner, winner_count, tie
  );

  // The result reader itself.
  modport slave (
    input  vote_en, vote_sel, clear, result_req, out_ready,
    output out_valid, out_cand, out_count, busy, done, winner, winner_count, tie
  );
endinterface

// File: rtl/evm_result_reader.sv
// EVM tally read-out: per-candidate saturating vote counters, a streamed
// valid/ready scan of all counts, and winner/tie tracking over that scan.
module evm_result_reader #(
  parameter int NUM_CAND = 4,
  parameter int CW       = 10,
  parameter int SW       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  evm_result_reader_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [SW-1:0] LAST_CAND = SW'(NUM_CAND - 1);

  state_t        state_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          tie_q;
  logic [SW-1:0] out_cand_q;
  logic [SW-1:0] winner_q;
  logic [CW-1:0] out_count_q;
  logic [CW-1:0] winner_count_q;

  // Read port over the full index space; slots past NUM_CAND read as zero so
  // any SW-bit index is safe.
  logic [CW-1:0] cnt_rd [2**SW];
  logic [SW-1:0] next_cand;
  logic          xfer;

  assign xfer      = out_valid_q & bus.out_ready;
  assign next_cand = out_cand_q + 1'b1;

  generate
    for (genvar gi = 0; gi < 2**SW; gi++) begin : gen_cnt
      if (gi < NUM_CAND) begin : g_live
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // Next count: votes only while the poll is open; clear wins over a vote.
        always_comb begin
          cnt_d = cnt_q;
          if (state_q == S_IDLE) begin
            if (bus.clear) begin
              cnt_d = '0;
            end else if (bus.vote_en && bus.vote_sel == SW'(gi) && cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (state_q == S_DONE && bus.clear) begin
            cnt_d = '0;
          end
        end

        // Counter storage.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) cnt_q <= '0;
          else     cnt_q <= cnt_d;
        end

        assign cnt_rd[gi] = cnt_q;
      end else begin : g_pad
        assign cnt_rd[gi] = '0;
      end
    end
  endgenerate

  // Poll/scan/result state machine with registered stream and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      tie_q          <= 1'b0;
      out_cand_q     <= '0;
      out_count_q    <= '0;
      winner_q       <= '0;
      winner_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.clear && bus.result_req) begin
            state_q     <= S_READ;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            out_cand_q  <= '0;
            // A vote landing in the request cycle must be visible in beat 0.
            out_count_q <= gen_cnt[0].g_live.cnt_d;
          end
        end

        S_READ: begin
          if (xfer) begin
            if (out_cand_q == '0) begin
              winner_q       <= '0;
              winner_count_q <= out_count_q;
              tie_q          <= 1'b0;
            end else if (out_count_q > winner_count_q) begin
              winner_q       <= out_cand_q;
              winner_count_q <= out_count_q;
              tie_q          <= 1'b0;
            end else if (out_count_q == winner_count_q) begin
              tie_q          <= 1'b1;
            end

            if (out_cand_q == LAST_CAND) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_cand_q  <= next_cand;
              out_count_q <= cnt_rd[next_cand];
            end
          end
        end

        S_DONE: begin
          if (bus.clear) begin
            state_q        <= S_IDLE;
            done_q         <= 1'b0;
            tie_q          <= 1'b0;
            winner_q       <= '0;
            winner_count_q <= '0;
          end else if (bus.result_req) begin
            state_q     <= S_READ;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            out_cand_q  <= '0;
            out_count_q <= cnt_rd[0];
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_cand     = out_cand_q;
  assign bus.out_count    = out_count_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.winner       = winner_q;
  assign bus.winner_count = winner_count_q;
  assign bus.tie          = tie_q;

endmodule

// File: tb/tb_evm_result_reader.sv
// Directed bench for evm_result_reader: a reference vote model feeds a beat
// scoreboard that is drained as the DUT streams, then the result is checked.
module tb_evm_result_reader;

  localparam int NC = 4;
  localparam int CW = 10;
  localparam int SW = 3;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    logic [SW-1:0] cand;
    logic [CW-1:0] count;
  } beat_t;

  logic  clk;
  logic  rst;
  int    checks;
  int    failures;
  int    model [NC];
  beat_t sb [$];

  evm_result_reader_if #(.SW(SW), .CW(CW)) bus ();

  evm_result_reader #(.NUM_CAND(NC), .CW(CW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_vote(input int c);
    if (c < NC && model[c] < MAXC) model[c]++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) model[i] = 0;
  endtask

  task automatic vote(input int c);
    bus.vote_en  = 1'b1;
    bus.vote_sel = SW'(c);
    model_vote(c);
    step();
    bus.vote_en  = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    model_clear();
  endtask

  // Expected result from the model: highest count, lowest index on ties.
  task automatic check_result();
    int maxv;
    int widx;
    int n;
    maxv = 0;
    widx = 0;
    n    = 0;
    for (int i = 0; i < NC; i++) if (model[i] > maxv) begin maxv = model[i]; widx = i; end
    for (int i = 0; i < NC; i++) if (model[i] == maxv) n++;
    check("done_after_scan", 32'(bus.done), 1);
    check("busy_after_scan", 32'(bus.busy), 0);
    check("valid_after_scan", 32'(bus.out_valid), 0);
    check("winner", 32'(bus.winner), widx);
    check("winner_count", 32'(bus.winner_count), maxv);
    check("tie", 32'(bus.tie), (n >= 2) ? 1 : 0);
  endtask

  // Request a scan and drain it. hold_at/hold_n stall a beat; vote_in_read
  // strobes votes during the stream; vote_with_req votes cand3 with the request.
  task automatic scan(input bit vote_with_req, input int hold_at, input int hold_n,
                      input bit vote_in_read);
    int    guard;
    int    held;
    beat_t b;
    guard = 0;
    held  = 0;
    if (vote_with_req) begin
      bus.vote_en  = 1'b1;
      bus.vote_sel = 3'd3;
      model_vote(3);
    end
    bus.result_req = 1'b1;
    for (int i = 0; i < NC; i++) sb.push_back('{cand: SW'(i), count: CW'(model[i])});
    step();
    bus.vote_en    = 1'b0;
    bus.result_req = 1'b0;
    check("busy_in_read", 32'(bus.busy), 1);
    check("done_in_read", 32'(bus.done), 0);
    while (sb.size() > 0 && guard < 40) begin
      guard++;
      if (vote_in_read) begin
        bus.vote_en  = 1'b1;
        bus.vote_sel = 3'd0;
      end
      check("beat_valid", 32'(bus.out_valid), 1);
      if (int'(bus.out_cand) == hold_at && held < hold_n) begin
        bus.out_ready = 1'b0;
        held++;
        check("hold_cand", 32'(bus.out_cand), 32'(sb[0].cand));
        check("hold_count", 32'(bus.out_count), 32'(sb[0].count));
      end else begin
        bus.out_ready = 1'b1;
        b = sb.pop_front();
        $display("beat cand=%0d count=%0d", bus.out_cand, bus.out_count);
        check("beat_cand", 32'(bus.out_cand), 32'(b.cand));
        check("beat_count", 32'(bus.out_count), 32'(b.count));
      end
      step();
    end
    bus.vote_en   = 1'b0;
    bus.out_ready = 1'b1;
    check("scan_drained", 32'(sb.size()), 0);
    sb.delete();
    check_result();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.vote_en    = 1'b0;
    bus.vote_sel   = '0;
    bus.clear      = 1'b0;
    bus.result_req = 1'b0;
    bus.out_ready  = 1'b1;
    model_clear();
    step();
    step();

    // Reset state.
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_tie", 32'(bus.tie), 0);
    check("rst_cand", 32'(bus.out_cand), 0);
    check("rst_count", 32'(bus.out_count), 0);
    check("rst_winner", 32'(bus.winner), 0);
    check("rst_wcount", 32'(bus.winner_count), 0);
    rst = 1'b0;

    // Basic tally and stream, then replay from DONE.
    vote(1); vote(1); vote(1); vote(2);
    scan(1'b0, -1, 0, 1'b0);
    scan(1'b0, -1, 0, 1'b0);

    // Clear from DONE returns to an open, empty poll.
    do_clear();
    check("clr_done", 32'(bus.done), 0);
    check("clr_busy", 32'(bus.busy), 0);
    check("clr_winner", 32'(bus.winner), 0);
    check("clr_wcount", 32'(bus.winner_count), 0);
    check("clr_tie", 32'(bus.tie), 0);

    // Vote and clear together: clear wins, cand2 stays 0 (seen in next scan).
    bus.vote_en  = 1'b1;
    bus.vote_sel = 3'd2;
    bus.clear    = 1'b1;
    step();
    bus.vote_en  = 1'b0;
    bus.clear    = 1'b0;

    // Tie on cand1/cand3, beat 1 stalled for 3 cycles, votes during READ ignored.
    vote(1); vote(1); vote(3); vote(3);
    scan(1'b0, 1, 3, 1'b1);
    scan(1'b0, -1, 0, 1'b0);

    // Asynchronous reset mid-scan aborts the stream.
    do_clear();
    bus.result_req = 1'b1;
    step();
    bus.result_req = 1'b0;
    check("abort_busy_pre", 32'(bus.busy), 1);
    step();
    #3 rst = 1'b1;
    #1;
    check("abort_valid", 32'(bus.out_valid), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_cand", 32'(bus.out_cand), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("abort_no_beat", 32'(bus.out_valid), 0);
    model_clear();

    // All-zero poll: winner 0, count 0, tie.
    scan(1'b0, -1, 0, 1'b0);

    // Saturation, out-of-range selects, and a vote in the request cycle.
    do_clear();
    for (int i = 0; i < MAXC + 5; i++) vote(0);
    vote(5); vote(5); vote(7);
    scan(1'b1, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
